// File: rtl/param_integer_datapath.sv
// Parameterised integer datapath: register file, ALU with flags,
// HI/LO registers and a bit-serial multiply/divide unit.
module param_integer_datapath #(
    parameter int DW = 32,
    parameter int RA = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [RA-1:0] S_Addr,
    input  logic [RA-1:0] T_Addr,
    input  logic [RA-1:0] D_Addr,
    input  logic          D_En,
    input  logic          T_Sel,
    input  logic [DW-1:0] DT,
    input  logic [DW-1:0] DY,
    input  logic [DW-1:0] PC_in,
    input  logic [3:0]    FS,
    input  logic [2:0]    Y_Sel,
    input  logic          HI_ld,
    input  logic          LO_ld,
    input  logic          MD_Start,
    input  logic [1:0]    MD_Op,
    output logic          MD_Busy,
    output logic          MD_Done,
    output logic          C,
    output logic          V,
    output logic          N,
    output logic          Z,
    output logic [DW-1:0] ALU_OUT,
    output logic [DW-1:0] D_OUT
);

    localparam int NR = 2 ** RA;
    localparam int SW = $clog2(DW);
    localparam int CW = $clog2(DW) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } md_state_e;

    logic [DW-1:0] rf_q [NR];
    logic [DW-1:0] s_op;
    logic [DW-1:0] t_op;

    md_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2*DW-1:0] acc_q, acc_d;
    logic [DW-1:0] b_q, b_d;
    logic [DW-1:0] a_raw_q, a_raw_d;
    logic          div_q, div_d;
    logic          qneg_q, qneg_d;
    logic          rneg_q, rneg_d;
    logic [DW-1:0] hi_q, hi_d;
    logic [DW-1:0] lo_q, lo_d;

    assign s_op  = rf_q[S_Addr];
    assign t_op  = T_Sel ? rf_q[T_Addr] : DT;
    assign D_OUT = t_op;

    // Register file write port; entry 0 is never written so it stays zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NR; i++) rf_q[i] <= '0;
        end else if (D_En && D_Addr != '0) begin
            rf_q[D_Addr] <= ALU_OUT;
        end
    end

    logic [DW-1:0] b_op;
    logic [DW:0]   sum_w;
    logic [DW:0]   dif_w;
    logic [SW-1:0] shamt;
    logic          add_v;
    logic          sub_v;
    logic [DW-1:0] alu_r;
    logic          carry;
    logic          ovf;

    assign b_op  = (FS == 4'd13 || FS == 4'd14) ? DW'(1) : t_op;
    assign sum_w = {1'b0, s_op} + {1'b0, b_op};
    assign dif_w = {1'b0, s_op} - {1'b0, b_op};
    assign shamt = t_op[SW-1:0];
    assign add_v = (s_op[DW-1] == b_op[DW-1]) &&
                   (sum_w[DW-1] != s_op[DW-1]);
    assign sub_v = (s_op[DW-1] != b_op[DW-1]) &&
                   (dif_w[DW-1] != s_op[DW-1]);

    // ALU function decode with carry/borrow and overflow for arithmetic ops.
    always_comb begin
        alu_r = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        unique case (FS)
            4'd0:  alu_r = s_op;
            4'd1:  alu_r = t_op;
            4'd2, 4'd13: begin
                alu_r = sum_w[DW-1:0];
                carry = sum_w[DW];
                ovf   = add_v;
            end
            4'd3, 4'd14: begin
                alu_r = dif_w[DW-1:0];
                carry = dif_w[DW];
                ovf   = sub_v;
            end
            4'd4:  alu_r = s_op & t_op;
            4'd5:  alu_r = s_op | t_op;
            4'd6:  alu_r = s_op ^ t_op;
            4'd7:  alu_r = ~(s_op | t_op);
            4'd8:  alu_r = {{(DW-1){1'b0}},
                            ($signed(s_op) < $signed(t_op))};
            4'd9:  alu_r = {{(DW-1){1'b0}}, (s_op < t_op)};
            4'd10: alu_r = s_op << shamt;
            4'd11: alu_r = s_op >> shamt;
            4'd12: alu_r = DW'($signed(s_op) >>> shamt);
            default: alu_r = '0;
        endcase
    end

    assign C = carry;
    assign V = ovf;
    assign N = alu_r[DW-1];
    assign Z = (alu_r == '0);

    // Result select, which is also the register write-back value.
    always_comb begin
        ALU_OUT = '0;
        unique case (Y_Sel)
            3'b000:  ALU_OUT = alu_r;
            3'b001:  ALU_OUT = hi_q;
            3'b010:  ALU_OUT = lo_q;
            3'b011:  ALU_OUT = DY;
            3'b100:  ALU_OUT = PC_in;
            default: ALU_OUT = '0;
        endcase
    end

    // Multiply/divide sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    logic last_step;
    assign last_step = (cnt_q == CW'(DW - 1));

    // Sequencer next state and status outputs.
    always_comb begin
        state_d = state_q;
        MD_Busy = 1'b0;
        MD_Done = 1'b0;
        unique case (state_q)
            IDLE: if (MD_Start) state_d = RUN;
            RUN: begin
                MD_Busy = 1'b1;
                if (last_step) state_d = DONE;
            end
            DONE: begin
                MD_Busy = 1'b1;
                MD_Done = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    logic          a_neg;
    logic          b_neg;
    logic [DW:0]   mul_sum;
    logic [2*DW-1:0] mul_nx;
    logic [DW:0]   div_sh;
    logic [DW:0]   div_df;
    logic [2*DW-1:0] div_nx;
    logic [2*DW-1:0] prod;
    logic [DW-1:0] quo;
    logic [DW-1:0] rem;

    assign a_neg   = MD_Op[0] & s_op[DW-1];
    assign b_neg   = MD_Op[0] & t_op[DW-1];
    assign mul_sum = {1'b0, acc_q[2*DW-1:DW]} +
                     (acc_q[0] ? {1'b0, b_q} : '0);
    assign mul_nx  = {mul_sum, acc_q[DW-1:1]};
    assign div_sh  = {acc_q[2*DW-1:DW], acc_q[DW-1]};
    assign div_df  = div_sh - {1'b0, b_q};
    assign div_nx  = div_df[DW] ?
                     {div_sh[DW-1:0], acc_q[DW-2:0], 1'b0} :
                     {div_df[DW-1:0], acc_q[DW-2:0], 1'b1};
    assign prod    = qneg_q ? -mul_nx : mul_nx;
    assign quo     = qneg_q ? -div_nx[DW-1:0] : div_nx[DW-1:0];
    assign rem     = rneg_q ? -div_nx[2*DW-1:DW] : div_nx[2*DW-1:DW];

    // Operand capture on magnitudes, one step per RUN cycle, sign fix-up
    // folded into the final step; HI/LO loads only while the unit is idle.
    always_comb begin
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        b_d     = b_q;
        a_raw_d = a_raw_q;
        div_d   = div_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (state_q == IDLE && MD_Start) begin
            acc_d   = {{DW{1'b0}}, (a_neg ? -s_op : s_op)};
            b_d     = b_neg ? -t_op : t_op;
            a_raw_d = s_op;
            div_d   = MD_Op[1];
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = a_neg;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            acc_d = div_q ? div_nx : mul_nx;
            cnt_d = cnt_q + 1'b1;
        end
        if (state_q == RUN && last_step) begin
            if (!div_q) begin
                hi_d = prod[2*DW-1:DW];
                lo_d = prod[DW-1:0];
            end else if (b_q == '0) begin
                hi_d = a_raw_q;
                lo_d = '1;
            end else begin
                hi_d = rem;
                lo_d = quo;
            end
        end else if (!MD_Busy) begin
            if (HI_ld) hi_d = s_op;
            if (LO_ld) lo_d = s_op;
        end
    end

    // Multiply/divide datapath and HI/LO registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            b_q     <= '0;
            a_raw_q <= '0;
            div_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            a_raw_q <= a_raw_d;
            div_q   <= div_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule

// File: tb/tb_param_integer_datapath.sv
// Randomised self-checking bench for param_integer_datapath (DW=32, RA=5)
// against an arithmetic reference model of registers, ALU and MD unit.
module tb_param_integer_datapath;

    localparam int DW = 32;
    localparam int RA = 5;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic          clk = 1'b0;
    logic          reset;
    logic [RA-1:0] S_Addr, T_Addr, D_Addr;
    logic          D_En, T_Sel;
    logic [DW-1:0] DT, DY, PC_in;
    logic [3:0]    FS;
    logic [2:0]    Y_Sel;
    logic          HI_ld, LO_ld, MD_Start;
    logic [1:0]    MD_Op;
    logic          MD_Busy, MD_Done, C, V, N, Z;
    logic [DW-1:0] ALU_OUT, D_OUT;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mrf [32];
    logic [31:0] mhi, mlo;

    param_integer_datapath #(.DW(DW), .RA(RA)) dut (
        .clk(clk), .reset(reset),
        .S_Addr(S_Addr), .T_Addr(T_Addr), .D_Addr(D_Addr),
        .D_En(D_En), .T_Sel(T_Sel),
        .DT(DT), .DY(DY), .PC_in(PC_in),
        .FS(FS), .Y_Sel(Y_Sel),
        .HI_ld(HI_ld), .LO_ld(LO_ld),
        .MD_Start(MD_Start), .MD_Op(MD_Op),
        .MD_Busy(MD_Busy), .MD_Done(MD_Done),
        .C(C), .V(V), .N(N), .Z(Z),
        .ALU_OUT(ALU_OUT), .D_OUT(D_OUT)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        D_En = 0; HI_ld = 0; LO_ld = 0; MD_Start = 0; MD_Op = 0;
        T_Sel = 1; FS = 0; Y_Sel = 0;
        S_Addr = 0; T_Addr = 0; D_Addr = 0;
        DT = 0; DY = 0; PC_in = 0;
    endtask

    function automatic logic ovf(input longint x);
        return (x > SMAX) || (x < SMIN);
    endfunction

    // returns {carry, overflow, result}
    function automatic logic [33:0] alu_ref(input logic [3:0] fs,
                                            input logic [31:0] s,
                                            input logic [31:0] t);
        longint ss, st, us, ut;
        logic [31:0] r;
        logic c, v;
        ss = longint'($signed(s));
        st = longint'($signed(t));
        us = longint'({32'b0, s});
        ut = longint'({32'b0, t});
        r = 0; c = 0; v = 0;
        case (fs)
            0: r = s;
            1: r = t;
            2: begin r = s + t; c = (us + ut) > 64'hFFFFFFFF;
                     v = ovf(ss + st); end
            3: begin r = s - t; c = us < ut; v = ovf(ss - st); end
            4: r = s & t;
            5: r = s | t;
            6: r = s ^ t;
            7: r = ~(s | t);
            8: r = (ss < st) ? 1 : 0;
            9: r = (us < ut) ? 1 : 0;
            10: r = s << t[4:0];
            11: r = s >> t[4:0];
            12: r = 32'(ss >>> t[4:0]);
            13: begin r = s + 1; c = (us + 1) > 64'hFFFFFFFF;
                      v = ovf(ss + 1); end
            14: begin r = s - 1; c = us < 1; v = ovf(ss - 1); end
            default: r = 0;
        endcase
        return {c, v, r};
    endfunction

    function automatic logic [31:0] yref(input logic [2:0] ys,
                                         input logic [31:0] a);
        case (ys)
            0: return a;
            1: return mhi;
            2: return mlo;
            3: return DY;
            4: return PC_in;
            default: return 0;
        endcase
    endfunction

    // returns {HI, LO}
    function automatic logic [63:0] md_ref(input logic [1:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            0: return 64'(a) * 64'(b);
            1: return 64'(sa * sb);
            2: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    // check combinational outputs for current inputs, clock, update model
    task automatic step_alu(input string tag);
        logic [31:0] s, t, y;
        logic [33:0] res;
        s = mrf[S_Addr];
        t = T_Sel ? mrf[T_Addr] : DT;
        res = alu_ref(FS, s, t);
        y = yref(Y_Sel, res[31:0]);
        #1;
        chk({tag, "_y"}, ALU_OUT, y);
        chk({tag, "_c"}, C, res[33]);
        chk({tag, "_v"}, V, res[32]);
        chk({tag, "_n"}, N, res[31]);
        chk({tag, "_z"}, Z, res[31:0] == 0);
        chk({tag, "_dout"}, D_OUT, t);
        tick;
        if (D_En && D_Addr != 0) mrf[D_Addr] = y;
        if (HI_ld) mhi = s;
        if (LO_ld) mlo = s;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] val);
        idle_inputs;
        D_En = 1; D_Addr = a; FS = 1; T_Sel = 0; DT = val;
        step_alu("wr");
    endtask

    task automatic md_run(input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b);
        logic [63:0] e;
        int n;
        wr(1, a);
        wr(2, b);
        e = md_ref(op, mrf[1], mrf[2]);
        idle_inputs;
        S_Addr = 1; T_Addr = 2; T_Sel = 1; MD_Op = op; MD_Start = 1;
        #1;
        chk({tag, "_idle_busy"}, MD_Busy, 0);
        tick;
        MD_Start = 1; HI_ld = 1; LO_ld = 1; S_Addr = 3;
        MD_Op = ~op;
        #1;
        chk({tag, "_busy"}, MD_Busy, 1);
        n = 1;
        while (!MD_Done && n < 100) begin
            tick;
            n++;
        end
        chk({tag, "_latency"}, n, DW + 1);
        Y_Sel = 1; #1;
        chk({tag, "_hi"}, ALU_OUT, e[63:32]);
        Y_Sel = 2; #1;
        chk({tag, "_lo"}, ALU_OUT, e[31:0]);
        chk({tag, "_busy_done"}, MD_Busy, 1);
        idle_inputs;
        tick;
        mhi = e[63:32];
        mlo = e[31:0];
        chk({tag, "_done_after"}, MD_Done, 0);
        chk({tag, "_busy_after"}, MD_Busy, 0);
        Y_Sel = 1; #1;
        chk({tag, "_hi_hold"}, ALU_OUT, mhi);
        Y_Sel = 0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcnt;
        for (int i = 0; i < 32; i++) mrf[i] = 0;
        mhi = 0;
        mlo = 0;
        idle_inputs;
        reset = 1;
        repeat (3) tick;
        reset = 0;
        #1;
        chk("rst_busy", MD_Busy, 0);
        chk("rst_done", MD_Done, 0);
        Y_Sel = 1; #1;
        chk("rst_hi", ALU_OUT, 0);
        Y_Sel = 2; #1;
        chk("rst_lo", ALU_OUT, 0);
        Y_Sel = 0; S_Addr = 5; #1;
        chk("rst_r5", ALU_OUT, 0);

        wr(1, 32'd7);
        wr(2, 32'hFFFFFFF9);
        idle_inputs;
        S_Addr = 1; T_Addr = 2; T_Sel = 1; FS = 2; #1;
        chk("add_wrap_y", ALU_OUT, 0);
        chk("add_wrap_c", C, 1);
        chk("add_wrap_v", V, 0);
        chk("add_wrap_z", Z, 1);
        tick;

        wr(1, 32'h7FFFFFFF);
        idle_inputs;
        S_Addr = 1; DT = 1; T_Sel = 0; FS = 2; #1;
        chk("add_ovf_y", ALU_OUT, 32'h80000000);
        chk("add_ovf_v", V, 1);
        chk("add_ovf_n", N, 1);
        tick;

        wr(0, 32'd5);
        idle_inputs;
        S_Addr = 0; #1;
        chk("r0_zero", ALU_OUT, 0);
        wr(1, 32'd7);
        wr(3, 32'h1234);
        idle_inputs;
        S_Addr = 1; T_Addr = 3; T_Sel = 1; D_En = 1; D_Addr = 3; #1;
        chk("rw_old", D_OUT, 32'h1234);
        tick;
        mrf[3] = 7;
        D_En = 0; #1;
        chk("rw_new", D_OUT, 32'd7);

        md_run("mult", 2'b01, -32'sd3, 32'd5);
        chk("mult_const_hi", mhi, 32'hFFFFFFFF);
        chk("mult_const_lo", mlo, 32'hFFFFFFF1);
        md_run("div", 2'b11, -32'sd7, 32'd2);
        md_run("divu0", 2'b10, 32'd9, 32'd0);
        md_run("divs0", 2'b11, -32'sd9, 32'd0);
        md_run("divmin", 2'b11, 32'h80000000, 32'hFFFFFFFF);
        md_run("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
        for (int i = 0; i < 10; i++) begin
            logic [31:0] b;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9))
                                            : $urandom;
            md_run("md_rnd", 2'($urandom_range(0, 3)), $urandom, b);
        end

        for (int i = 0; i < 80; i++) begin
            idle_inputs;
            S_Addr = 5'($urandom); T_Addr = 5'($urandom);
            D_Addr = 5'($urandom); D_En = 1'($urandom);
            T_Sel = 1'($urandom); DT = $urandom;
            DY = $urandom; PC_in = $urandom;
            FS = 4'($urandom); Y_Sel = 3'($urandom_range(0, 7));
            HI_ld = ($urandom_range(0, 7) == 0);
            LO_ld = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) Y_Sel = 0;
            step_alu("rnd");
        end

        wr(1, $urandom);
        wr(2, $urandom);
        idle_inputs;
        S_Addr = 1; T_Addr = 2; MD_Op = 2'b00; MD_Start = 1;
        tick;
        MD_Start = 1;
        repeat (9) tick;
        reset = 1;
        tick;
        idle_inputs;
        reset = 0;
        for (int i = 0; i < 32; i++) mrf[i] = 0;
        mhi = 0;
        mlo = 0;
        #1;
        chk("abort_busy", MD_Busy, 0);
        chk("abort_done", MD_Done, 0);
        Y_Sel = 1; #1;
        chk("abort_hi", ALU_OUT, 0);
        Y_Sel = 2; #1;
        chk("abort_lo", ALU_OUT, 0);
        Y_Sel = 0; S_Addr = 1; #1;
        chk("abort_r1", ALU_OUT, 0);
        dcnt = 0;
        repeat (40) begin
            tick;
            if (MD_Done || MD_Busy) dcnt++;
        end
        chk("abort_quiet", dcnt, 0);

        md_run("post_abort", 2'b01, $urandom, $urandom);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
